// File: rtl/paraseri_pkg.sv
// Shared types and helpers for the paraseri parallel-to-serial transmitter.
package paraseri_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_e;

    localparam int unsigned W_DEF   = 4;
    localparam int unsigned GAP_MAX = 15;
    localparam int unsigned GAP_CW  = 4;

    // Bit-index width; a 2-bit word still needs one index bit.
    function automatic int unsigned idx_width(input int unsigned w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/paraseri_buf.sv
// One-entry holding register between the load handshake and the shifter.
module paraseri_buf
    import paraseri_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic         clk,
    input  logic         res,
    input  logic         load,
    input  logic [W-1:0] d,
    input  logic         take,
    output logic         ready,
    output logic         valid,
    output logic [W-1:0] data
);

    logic         ready_q;
    logic [W-1:0] data_q;

    // Accept only when empty; take only when full, so the two never coincide.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            ready_q <= 1'b1;
            data_q  <= '0;
        end else if (load && ready_q) begin
            data_q  <= d;
            ready_q <= 1'b0;
        end else if (take && !ready_q) begin
            ready_q <= 1'b1;
        end
    end

    assign ready = ready_q;
    assign valid = ~ready_q;
    assign data  = data_q;

endmodule

// File: rtl/paraseri.sv
// Parallel-to-serial transmitter: buffered word shifted out MSB first with a per-bit strobe.
module paraseri
    import paraseri_pkg::*;
#(
    parameter int unsigned W   = W_DEF,
    parameter int unsigned GAP = 0
) (
    input  logic         clk,
    input  logic         res,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic         ready,
    input  logic         hold,
    output logic         so,
    output logic         ena,
    output logic         frame_done,
    output logic         busy
);

    localparam int unsigned IW = idx_width(W);

    state_e              state_q;
    logic [W-1:0]        shreg_q;
    logic [IW-1:0]       idx_q;
    logic [GAP_CW-1:0]   gap_q;
    logic                active_q;
    logic                fd_q;

    logic                buf_valid_c;
    logic [W-1:0]        buf_data_c;
    logic                consume_c;
    logic                last_c;
    logic                take_c;

    assign consume_c = active_q & ~hold;
    assign last_c    = consume_c && (idx_q == '0);

    // The buffer drains into the shifter from IDLE, or back-to-back at frame end when no gap is configured.
    assign take_c = buf_valid_c &&
                    ((state_q == S_IDLE) ||
                     ((state_q == S_SHIFT) && last_c && (GAP == 0)));

    paraseri_buf #(.W(W)) u_buf (
        .clk   (clk),
        .res   (res),
        .load  (load),
        .d     (d),
        .take  (take_c),
        .ready (ready),
        .valid (buf_valid_c),
        .data  (buf_data_c)
    );

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            idx_q    <= IW'(W - 1);
            gap_q    <= '0;
            active_q <= 1'b0;
            fd_q     <= 1'b0;
        end else begin
            fd_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (buf_valid_c) begin
                        shreg_q  <= buf_data_c;
                        idx_q    <= IW'(W - 1);
                        active_q <= 1'b1;
                        state_q  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (consume_c) begin
                        if (idx_q != '0) begin
                            shreg_q <= {shreg_q[W-2:0], 1'b0};
                            idx_q   <= idx_q - IW'(1);
                        end else begin
                            // Last bit consumed: shreg is left untouched so so keeps the final bit.
                            fd_q <= 1'b1;
                            if (GAP != 0) begin
                                gap_q    <= GAP_CW'(GAP);
                                active_q <= 1'b0;
                                state_q  <= S_GAP;
                            end else if (buf_valid_c) begin
                                shreg_q <= buf_data_c;
                                idx_q   <= IW'(W - 1);
                            end else begin
                                active_q <= 1'b0;
                                state_q  <= S_IDLE;
                            end
                        end
                    end
                end
                S_GAP: begin
                    gap_q <= gap_q - GAP_CW'(1);
                    if (gap_q == GAP_CW'(1)) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    active_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign so         = shreg_q[W-1];
    assign ena        = active_q & ~hold;
    assign frame_done = fd_q;
    assign busy       = buf_valid_c | (state_q != S_IDLE);

endmodule

// File: tb/tb_paraseri.sv
// Bench for paraseri: two instances (GAP=0, GAP=2) against a word/bit-queue reference model.
module tb_paraseri;

    localparam int unsigned W  = 4;
    localparam int unsigned NI = 2;

    logic          clk;
    logic          res;
    logic          load;
    logic          hold;
    logic [W-1:0]  d;
    logic [NI-1:0] ready_w, so_w, ena_w, fd_w, busy_w;

    paraseri #(.W(W), .GAP(0)) u_dut0 (
        .clk(clk), .res(res), .load(load), .d(d), .ready(ready_w[0]), .hold(hold),
        .so(so_w[0]), .ena(ena_w[0]), .frame_done(fd_w[0]), .busy(busy_w[0])
    );

    paraseri #(.W(W), .GAP(2)) u_dut1 (
        .clk(clk), .res(res), .load(load), .d(d), .ready(ready_w[1]), .hold(hold),
        .so(so_w[1]), .ena(ena_w[1]), .frame_done(fd_w[1]), .busy(busy_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: the frame in flight is a word plus a count of bits still to send.
    int unsigned  m_left [NI];
    logic [W-1:0] m_word [NI];
    logic [W-1:0] m_pw   [NI];
    bit           m_pv   [NI];
    int unsigned  m_lock [NI];
    bit           m_lso  [NI];
    bit           m_fd   [NI];
    logic [W-1:0] expq0[$];
    logic [W-1:0] expq1[$];
    logic [W-1:0] rx     [NI];
    int unsigned  rx_n   [NI];

    function automatic int unsigned gap_of(input int k);
        return (k == 0) ? 0 : 2;
    endfunction

    task automatic check(input string tag, input int k, input logic [15:0] got, input logic [15:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d]: observed %0h expected %0h", tag, k, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_left[k] = 0; m_word[k] = '0; m_pw[k] = '0; m_pv[k] = 0;
            m_lock[k] = 0; m_lso[k] = 0; m_fd[k] = 0; rx[k] = '0; rx_n[k] = 0;
        end
        expq0.delete();
        expq1.delete();
    endtask

    task automatic model_edge(input int k);
        bit pre_pv;
        pre_pv  = m_pv[k];
        m_fd[k] = 0;
        if (m_left[k] > 0) begin
            if (!hold) begin
                m_lso[k] = m_word[k][m_left[k]-1];
                m_left[k]--;
                if (m_left[k] == 0) begin
                    m_fd[k] = 1;
                    if (gap_of(k) == 0 && pre_pv) begin
                        m_word[k] = m_pw[k]; m_left[k] = W; m_pv[k] = 0;
                    end else begin
                        m_lock[k] = gap_of(k);
                    end
                end
            end
        end else if (m_lock[k] > 0) begin
            m_lock[k]--;
        end else if (pre_pv) begin
            m_word[k] = m_pw[k]; m_left[k] = W; m_pv[k] = 0;
        end
        if (load && !pre_pv) begin
            m_pw[k] = d; m_pv[k] = 1;
            if (k == 0) expq0.push_back(d); else expq1.push_back(d);
        end
    endtask

    task automatic check_outputs();
        bit           e_ena, e_so, e_busy;
        logic [W-1:0] e_word;
        for (int k = 0; k < NI; k++) begin
            e_ena  = (m_left[k] > 0) && !hold;
            e_so   = (m_left[k] > 0) ? m_word[k][m_left[k]-1] : m_lso[k];
            e_busy = m_pv[k] || (m_left[k] > 0) || (m_lock[k] > 0);
            check("ready", k, 16'(ready_w[k]), 16'(!m_pv[k]));
            check("busy",  k, 16'(busy_w[k]),  16'(e_busy));
            check("so",    k, 16'(so_w[k]),    16'(e_so));
            check("ena",   k, 16'(ena_w[k]),   16'(e_ena));
            check("frame_done", k, 16'(fd_w[k]), 16'(m_fd[k]));
            // Receiver view: collect strobed bits MSB first and compare whole words.
            if (ena_w[k] === 1'b1 && e_ena) begin
                rx[k] = {rx[k][W-2:0], so_w[k]};
                rx_n[k]++;
                if (rx_n[k] == W) begin
                    rx_n[k] = 0;
                    e_word  = ~rx[k];
                    if (k == 0 && expq0.size() > 0) e_word = expq0.pop_front();
                    if (k == 1 && expq1.size() > 0) e_word = expq1.pop_front();
                    check("rx_word", k, 16'(rx[k]), 16'(e_word));
                end
            end
        end
    endtask

    task automatic step(input bit l, input logic [W-1:0] dv, input bit h);
        load = l; d = dv; hold = h;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        for (int k = 0; k < NI; k++) model_edge(k);
        #1;
    endtask

    task automatic do_reset();
        load = 1'b0; hold = 1'b0; res = 1'b1;
        model_reset();
        #2;
        check_outputs();
        @(negedge clk);
        res = 1'b0;
        @(posedge clk);
        for (int k = 0; k < NI; k++) model_edge(k);
        #1;
    endtask

    task automatic push(input int k, input logic [W-1:0] w);
        for (int g = 0; g < 40 && m_pv[k]; g++) step(1'b0, '0, 1'b0);
        step(1'b1, w, 1'b0);
    endtask

    task automatic wait_left(input int k, input int unsigned n);
        for (int g = 0; g < 40 && m_left[k] != n; g++) step(1'b0, '0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, 1'b0);
    endtask

    initial begin
        res = 1'b0; load = 1'b0; hold = 1'b0; d = '0;
        model_reset();
        #1;
        do_reset();

        // Single frame 1100
        push(0, 4'b1100);
        idle(8);

        // Back-to-back frames on the no-gap instance
        push(0, 4'b1010);
        push(0, 4'b0110);
        idle(12);

        // Load while the buffer is full must be ignored
        push(0, 4'b0011);
        push(0, 4'b1101);
        step(1'b1, 4'b0101, 1'b0);
        idle(14);

        // Hold for three cycles while the second bit is presented
        push(0, 4'b1001);
        wait_left(0, 3);
        repeat (3) step(1'b0, '0, 1'b1);
        idle(8);

        // Gap instance with two queued words
        push(1, 4'b1111);
        push(1, 4'b0001);
        idle(20);

        // Reset after two bits, then a fresh frame
        push(0, 4'b1110);
        wait_left(0, 2);
        do_reset();
        push(0, 4'b0111);
        idle(10);

        // Randomized traffic with occasional resets
        repeat (600) begin
            if ($urandom_range(0, 249) == 0) do_reset();
            else step($urandom_range(0, 2) == 0, W'($urandom), $urandom_range(0, 4) == 0);
        end
        idle(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
